entrada_chaves: RTL and testbench
=================================

Name: entrada_chaves

Overview:
Input-capture stage directly upstream of the CPU switch input. Synchronises and debounces a raw pushbutton and synchronises the 7 board switches. While the CPU controller requests input (its input-wait flag), the block waits for one clean button press, then latches the switch value and drives it to the CPU switch bus with a one-cycle valid pulse. Guarantees exactly one capture per request, whatever the button bounce or hold time.

Parameters:
DATA_WIDTH, 7, switch/data width
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change (1 ms at 50 MHz); minimum 2
BOTAO_ATIVO_BAIXO, 1, 1 = raw button reads 0 when pressed (board key), 0 = reads 1 when pressed

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high; clears all state
chaves_raw  input  DATA_WIDTH  raw board switches, asynchronous
botao_raw  input  1  raw confirm pushbutton, asynchronous, bouncing
pedido  input  1  level from CPU controller: 1 = CPU waiting for input
dados_out  output  DATA_WIDTH  captured value, feeds CPU switches bus; held between captures
dado_valido  output  1  one-cycle pulse: dados_out updated this cycle
aguardando  output  1  1 while waiting for a press (for a board LED)

Behaviour:
- Reset (async assert, sync release): dados_out=0, dado_valido=0, aguardando=0, FSM=OCIOSO, debounce counter=0, all sync flops and debounced button = "released" level (normalised press=0).
- Synchronisers: 2-flop chain on each chaves_raw bit and on botao_raw; button normalised to press=1 after sync using BOTAO_ATIVO_BAIXO.
- Debounce: counter increments each cycle synced button != debounced button, clears to 0 on any cycle they are equal. When counter reaches DEBOUNCE_CYCLES-1 and still differs, debounced button toggles next edge and counter clears. Net latency raw change -> debounced change = 2 + DEBOUNCE_CYCLES cycles for a clean edge; pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- press_edge = debounced rises (registered previous-value compare), one cycle wide.
- FSM states and transitions (evaluated each rising edge):
  - OCIOSO: pedido=1 and debounced=pressed -> ESPERA_SOLTO; pedido=1 and released -> ESPERA_PRESS; else stay.
  - ESPERA_SOLTO: button held from earlier; pedido=0 -> OCIOSO; debounced released -> ESPERA_PRESS.
  - ESPERA_PRESS: pedido=0 -> OCIOSO (no capture, dados_out unchanged); press_edge -> CAPTURA, dados_out <= synced switches in that same edge.
  - CAPTURA: exactly one cycle; dado_valido=1; -> ESPERA_FIM.
  - ESPERA_FIM: stay until pedido=0 -> OCIOSO. Further presses ignored.
- pedido=0 and press_edge in the same cycle in ESPERA_PRESS: pedido wins, no capture.
- aguardando=1 exactly in ESPERA_SOLTO and ESPERA_PRESS; registered (state-decoded), 0 elsewhere.
- dado_valido is registered, never high two consecutive cycles, never high outside CAPTURA.
- Switch value captured is the synchronised value at the press_edge cycle; switch changes afterward do not affect dados_out until the next capture.
- Reset mid-operation (any state, including CAPTURA): all outputs return to reset values immediately; a press in progress must be released and re-pressed after a new pedido.
- Counter width = clog2(DEBOUNCE_CYCLES); no wrap possible since it clears on reaching the limit.

Test Plan:
- Reset: assert reset with button pressed and pedido=1 -> dados_out=0, dado_valido=0, aguardando=0 during and 1 cycle after release; press required again.
- Clean capture (DEBOUNCE_CYCLES=4, active-low): chaves_raw=7'h5A, pedido=1, botao_raw 1->0 held 10 cycles -> dado_valido single pulse 2+4+2 cycles after the fall, dados_out=7'h5A, aguardando falls with the pulse.
- Bounce: botao_raw toggles every 2 cycles for 12 cycles then low -> exactly one dado_valido; glitch of 3 cycles alone -> no pulse.
- Held button at request: button already pressed when pedido rises -> state ESPERA_SOLTO, no capture until released then pressed; chaves_raw=7'h13 at second press -> dados_out=7'h13.
- Abort: pedido drops in ESPERA_PRESS (same cycle as press_edge) -> no pulse, dados_out keeps previous 7'h5A, FSM OCIOSO.
- Single capture per request: pedido held high, three separate presses with switches 1,2,3 -> one pulse, dados_out=1; drop and re-raise pedido, press -> dados_out updates.

Source files
------------

// File: rtl/entrada_chaves.sv
// Input-capture stage for the CPU switch bus: synchronises and debounces the confirm
// button, then latches the synchronised switches once per CPU input request.
module entrada_chaves #(
    parameter int DATA_WIDTH        = 7,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] chaves_raw,
    input  logic                  botao_raw,
    input  logic                  pedido,
    output logic [DATA_WIDTH-1:0] dados_out,
    output logic                  dado_valido,
    output logic                  aguardando
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic SOLTO_RAW = BOTAO_ATIVO_BAIXO;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_SOLTO,
        ESPERA_PRESS,
        CAPTURA,
        ESPERA_FIM
    } estado_t;

    estado_t               estado;
    logic                  reset_meta;
    logic                  reset_interno;
    logic [DATA_WIDTH-1:0] chaves_s1;
    logic [DATA_WIDTH-1:0] chaves_s2;
    logic                  botao_s1;
    logic                  botao_s2;
    logic                  botao_sync;
    logic [CNT_W-1:0]      contador;
    logic                  botao_deb;
    logic                  botao_deb_ant;
    logic                  press_edge;
    logic [1:0]            inicio;
    logic                  armado;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reset_meta    <= 1'b1;
            reset_interno <= 1'b1;
        end else begin
            reset_meta    <= 1'b0;
            reset_interno <= reset_meta;
        end
    end

    always_ff @(posedge clock or posedge reset_interno) begin
        if (reset_interno) begin
            chaves_s1 <= '0;
            chaves_s2 <= '0;
            botao_s1  <= SOLTO_RAW;
            botao_s2  <= SOLTO_RAW;
        end else begin
            chaves_s1 <= chaves_raw;
            chaves_s2 <= chaves_s1;
            botao_s1  <= botao_raw;
            botao_s2  <= botao_s1;
        end
    end

    assign botao_sync = BOTAO_ATIVO_BAIXO ? ~botao_s2 : botao_s2;

    // armado stays low after reset until the button is seen released, so a press
    // already in progress when reset lifts is never taken as a new one.
    always_ff @(posedge clock or posedge reset_interno) begin
        if (reset_interno) begin
            contador      <= '0;
            botao_deb     <= 1'b0;
            botao_deb_ant <= 1'b0;
            press_edge    <= 1'b0;
            inicio        <= 2'b00;
            armado        <= 1'b0;
        end else begin
            botao_deb_ant <= botao_deb;
            press_edge    <= botao_deb & ~botao_deb_ant;
            inicio        <= {inicio[0], 1'b1};
            if (botao_sync != botao_deb) begin
                if (contador == CNT_MAX) begin
                    botao_deb <= ~botao_deb;
                    contador  <= '0;
                end else begin
                    contador <= contador + CNT_W'(1);
                end
            end else begin
                contador <= '0;
            end
            if (inicio[1] && !botao_sync && !botao_deb) begin
                armado <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset_interno) begin
        if (reset_interno) begin
            estado      <= OCIOSO;
            dados_out   <= '0;
            dado_valido <= 1'b0;
            aguardando  <= 1'b0;
        end else begin
            dado_valido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (pedido && inicio[1]) begin
                        aguardando <= 1'b1;
                        if (botao_deb || !armado) begin
                            estado <= ESPERA_SOLTO;
                        end else begin
                            estado <= ESPERA_PRESS;
                        end
                    end
                end
                ESPERA_SOLTO: begin
                    if (!pedido) begin
                        estado     <= OCIOSO;
                        aguardando <= 1'b0;
                    end else if (armado && !botao_deb) begin
                        estado <= ESPERA_PRESS;
                    end
                end
                // A dropped request wins over a simultaneous press.
                ESPERA_PRESS: begin
                    if (!pedido) begin
                        estado     <= OCIOSO;
                        aguardando <= 1'b0;
                    end else if (press_edge) begin
                        estado      <= CAPTURA;
                        dados_out   <= chaves_s2;
                        dado_valido <= 1'b1;
                        aguardando  <= 1'b0;
                    end
                end
                CAPTURA: begin
                    estado <= ESPERA_FIM;
                end
                ESPERA_FIM: begin
                    if (!pedido) begin
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    estado     <= OCIOSO;
                    aguardando <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entrada_chaves.sv
// Directed bench for entrada_chaves with a short debounce window and an active-low key.
module tb_entrada_chaves;

    logic       clock;
    logic       reset;
    logic [6:0] chaves_raw;
    logic       botao_raw;
    logic       pedido;
    logic [6:0] dados_out;
    logic       dado_valido;
    logic       aguardando;

    int checks;
    int failures;
    int double_pulses;
    logic valid_prev;

    entrada_chaves #(
        .DATA_WIDTH(7),
        .DEBOUNCE_CYCLES(4),
        .BOTAO_ATIVO_BAIXO(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .chaves_raw(chaves_raw),
        .botao_raw(botao_raw),
        .pedido(pedido),
        .dados_out(dados_out),
        .dado_valido(dado_valido),
        .aguardando(aguardando)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        double_pulses = 0;
        valid_prev    = 1'b0;
    end

    always @(negedge clock) begin
        if (dado_valido === 1'b1 && valid_prev === 1'b1) begin
            double_pulses++;
        end
        valid_prev = dado_valido;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] chaves, input logic pressed, input logic ped);
        chaves_raw = chaves;
        botao_raw  = ~pressed;
        pedido     = ped;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts dado_valido samples over n cycles; first is the 1-based cycle of the first pulse.
    task automatic watch_pulse(input int n, output int count, output int first);
        count = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (dado_valido === 1'b1) begin
                count++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        int count;
        int first;
        int sum;
        logic ag7;
        logic ag8;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(7'h00, 1'b1, 1'b1);

        // Reset with the button held and a request pending
        wait_cycles(3);
        checkOutput("reset_dados", 32'(dados_out), 32'h00);
        checkOutput("reset_valido", 32'(dado_valido), 32'h0);
        checkOutput("reset_aguardando", 32'(aguardando), 32'h0);
        reset = 1'b0;
        wait_cycles(1);
        checkOutput("post_reset_aguardando", 32'(aguardando), 32'h0);
        checkOutput("post_reset_valido", 32'(dado_valido), 32'h0);
        watch_pulse(25, count, first);
        checkOutput("held_after_reset_no_pulse", 32'(count), 32'd0);
        checkOutput("held_after_reset_waiting", 32'(aguardando), 32'h1);
        applyStimulus(7'h00, 1'b0, 1'b1);
        watch_pulse(12, count, first);
        checkOutput("release_after_reset_no_pulse", 32'(count), 32'd0);
        checkOutput("release_after_reset_dados", 32'(dados_out), 32'h00);
        applyStimulus(7'h33, 1'b1, 1'b1);
        watch_pulse(12, count, first);
        checkOutput("repress_after_reset_pulses", 32'(count), 32'd1);
        checkOutput("repress_after_reset_dados", 32'(dados_out), 32'h33);
        applyStimulus(7'h33, 1'b0, 1'b1);
        wait_cycles(10);
        pedido = 1'b0;
        wait_cycles(2);
        checkOutput("idle_aguardando", 32'(aguardando), 32'h0);

        // Clean capture of 0x5A
        applyStimulus(7'h5A, 1'b0, 1'b1);
        wait_cycles(3);
        checkOutput("clean_waiting", 32'(aguardando), 32'h1);
        botao_raw = 1'b0;
        count = 0;
        first = 0;
        ag7 = 1'b0;
        ag8 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (dado_valido === 1'b1) begin
                count++;
                if (first == 0) first = i;
            end
            if (i == 7) ag7 = aguardando;
            if (i == 8) ag8 = aguardando;
        end
        checkOutput("clean_pulses", 32'(count), 32'd1);
        checkOutput("clean_latency", 32'(first), 32'd8);
        checkOutput("clean_waiting_before", 32'(ag7), 32'h1);
        checkOutput("clean_waiting_at_pulse", 32'(ag8), 32'h0);
        checkOutput("clean_dados", 32'(dados_out), 32'h5A);
        chaves_raw = 7'h00;
        wait_cycles(2);
        checkOutput("clean_dados_held", 32'(dados_out), 32'h5A);
        botao_raw = 1'b1;
        wait_cycles(10);
        checkOutput("clean_done_not_waiting", 32'(aguardando), 32'h0);
        pedido = 1'b0;
        wait_cycles(2);

        // Abort: request drops in the same cycle as the press edge
        applyStimulus(7'h7F, 1'b0, 1'b1);
        wait_cycles(3);
        botao_raw = 1'b0;
        count = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (dado_valido === 1'b1) count++;
            if (i == 7) pedido = 1'b0;
        end
        checkOutput("abort_pulses", 32'(count), 32'd0);
        checkOutput("abort_dados", 32'(dados_out), 32'h5A);
        checkOutput("abort_aguardando", 32'(aguardando), 32'h0);
        botao_raw = 1'b1;
        wait_cycles(10);

        // Button already held when the request rises
        applyStimulus(7'h7F, 1'b1, 1'b0);
        wait_cycles(12);
        pedido = 1'b1;
        wait_cycles(3);
        checkOutput("held_waiting", 32'(aguardando), 32'h1);
        watch_pulse(10, count, first);
        checkOutput("held_no_pulse", 32'(count), 32'd0);
        botao_raw = 1'b1;
        wait_cycles(12);
        applyStimulus(7'h13, 1'b1, 1'b1);
        watch_pulse(12, count, first);
        checkOutput("held_repress_pulses", 32'(count), 32'd1);
        checkOutput("held_repress_latency", 32'(first), 32'd8);
        checkOutput("held_repress_dados", 32'(dados_out), 32'h13);
        botao_raw = 1'b1;
        wait_cycles(10);
        pedido = 1'b0;
        wait_cycles(2);

        // Bouncing press settles into exactly one capture
        applyStimulus(7'h21, 1'b0, 1'b1);
        wait_cycles(3);
        count = 0;
        for (int k = 0; k < 12; k++) begin
            botao_raw = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (dado_valido === 1'b1) count++;
        end
        botao_raw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (dado_valido === 1'b1) count++;
        end
        checkOutput("bounce_pulses", 32'(count), 32'd1);
        checkOutput("bounce_dados", 32'(dados_out), 32'h21);
        botao_raw = 1'b1;
        wait_cycles(10);
        pedido = 1'b0;
        wait_cycles(2);

        // A 3-cycle glitch is shorter than the debounce window
        applyStimulus(7'h44, 1'b0, 1'b1);
        wait_cycles(3);
        botao_raw = 1'b0;
        wait_cycles(3);
        botao_raw = 1'b1;
        watch_pulse(15, count, first);
        checkOutput("glitch_pulses", 32'(count), 32'd0);
        checkOutput("glitch_waiting", 32'(aguardando), 32'h1);
        checkOutput("glitch_dados", 32'(dados_out), 32'h21);
        pedido = 1'b0;
        wait_cycles(2);

        // Three presses under one request give a single capture
        applyStimulus(7'h00, 1'b0, 1'b1);
        wait_cycles(3);
        sum = 0;
        for (int v = 1; v <= 3; v++) begin
            applyStimulus(7'(v), 1'b1, 1'b1);
            watch_pulse(12, count, first);
            sum += count;
            botao_raw = 1'b1;
            wait_cycles(10);
        end
        checkOutput("single_req_pulses", 32'(sum), 32'd1);
        checkOutput("single_req_dados", 32'(dados_out), 32'h01);
        checkOutput("single_req_not_waiting", 32'(aguardando), 32'h0);
        pedido = 1'b0;
        wait_cycles(2);
        pedido = 1'b1;
        wait_cycles(3);
        applyStimulus(7'h04, 1'b1, 1'b1);
        watch_pulse(12, count, first);
        checkOutput("new_req_pulses", 32'(count), 32'd1);
        checkOutput("new_req_dados", 32'(dados_out), 32'h04);
        botao_raw = 1'b1;
        wait_cycles(10);

        // Reset in the middle of a request clears outputs at once
        reset = 1'b1;
        #1;
        checkOutput("midreset_dados", 32'(dados_out), 32'h00);
        checkOutput("midreset_aguardando", 32'(aguardando), 32'h0);
        checkOutput("midreset_valido", 32'(dado_valido), 32'h0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(3);

        checkOutput("valid_never_consecutive", 32'(double_pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
